frame_pattern_writer: RTL

//  Generates one full test frame (row-major, H_DISP*V_DISP pixels) and writes it into the

---
 rtl/frame_pattern_writer_pkg.sv | 34 +++
 rtl/frame_pattern_pixel.sv | 74 +++++++
 rtl/frame_pattern_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/frame_pattern_writer_pkg.sv
// Shared types and constants for the test-frame writer: FSM states, pattern codes and
// the colour-bar palette.
package frame_pattern_writer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLoad,
        StWrite,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PatBars    = 2'd0,
        PatChecker = 2'd1,
        PatRamp    = 2'd2,
        PatBorder  = 2'd3
    } pattern_e;

    localparam logic [23:0] ColWhite = 24'hFFFFFF;
    localparam logic [23:0] ColBlack = 24'h000000;
    localparam logic [23:0] ColBlue  = 24'h0000FF;

    localparam logic [23:0] BarColour [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // A divide setting of zero behaves like one: a write every cycle.
    function automatic logic [7:0] eff_divide(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

endpackage

// File: rtl/frame_pattern_pixel.sv
// Pixel position tracking and pattern generation; the pixel colour is registered on each
// advance so it lines up with the write strobe registered in the parent.
module frame_pattern_pixel
    import frame_pattern_writer_pkg::*;
#(
    parameter int unsigned H_DISP = 1280,
    parameter int unsigned V_DISP = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        advance,
    input  pattern_e    pattern,
    output logic [23:0] pix_data,
    output logic        last_pixel
);

    localparam int unsigned BarW = H_DISP / 8;

    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [15:0] bar_x_q;
    logic [2:0]  bar_q;
    logic [23:0] colour;
    logic        on_border;

    assign last_pixel = (x_q == 16'(H_DISP - 1)) && (y_q == 16'(V_DISP - 1));
    assign on_border  = (x_q == 16'd0) || (x_q == 16'(H_DISP - 1)) ||
                        (y_q == 16'd0) || (y_q == 16'(V_DISP - 1));

    always_comb begin
        colour = ColBlack;
        unique case (pattern)
            PatBars:    colour = BarColour[bar_q];
            PatChecker: colour = (x_q[5] ^ y_q[5]) ? ColWhite : ColBlack;
            PatRamp:    colour = {3{x_q[7:0]}};
            PatBorder:  colour = on_border ? ColWhite : ColBlue;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            bar_x_q  <= '0;
            bar_q    <= '0;
            pix_data <= '0;
        end else if (clear) begin
            x_q     <= '0;
            y_q     <= '0;
            bar_x_q <= '0;
            bar_q   <= '0;
        end else if (advance) begin
            pix_data <= colour;
            if (x_q == 16'(H_DISP - 1)) begin
                x_q     <= '0;
                bar_x_q <= '0;
                bar_q   <= '0;
                y_q     <= (y_q == 16'(V_DISP - 1)) ? 16'd0 : y_q + 16'd1;
            end else begin
                x_q <= x_q + 16'd1;
                // Bar index tracked by counting, avoiding a divider on x.
                if (bar_x_q == 16'(BarW - 1)) begin
                    bar_x_q <= '0;
                    bar_q   <= bar_q + 3'd1;
                end else begin
                    bar_x_q <= bar_x_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_pattern_writer.sv
// Writes one rate-throttled test frame into the SDRAM write-port FIFO after init, then
// idles in DONE until a restart pulse.
module frame_pattern_writer
    import frame_pattern_writer_pkg::*;
#(
    parameter int unsigned H_DISP      = 1280,
    parameter int unsigned V_DISP      = 720,
    parameter int unsigned START_DELAY = 1024,
    parameter int unsigned LOAD_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_vaild,
    input  logic        restart,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  DIVIDE_PARAM,
    output logic        sys_load,
    output logic        sys_we,
    output logic [23:0] sys_data,
    output logic [31:0] sys_addr_min,
    output logic [31:0] sys_addr_max,
    output logic        frame_done
);

    localparam int unsigned DlyMax = (START_DELAY > LOAD_LEN) ? START_DELAY : LOAD_LEN;
    localparam int unsigned DlyW   = $clog2(DlyMax + 1);

    state_e          state_q;
    pattern_e        pattern_q;
    logic [DlyW-1:0] dly_q;
    logic [7:0]      thr_q;
    logic            write_hit;
    logic            pix_clear;
    logic            last_pixel;

    assign sys_addr_min = 32'd0;
    assign sys_addr_max = 32'(H_DISP * V_DISP);

    // A falling sys_vaild suppresses the write that would have landed on the same edge.
    assign write_hit = (state_q == StWrite) && sys_vaild &&
                       (thr_q >= eff_divide(DIVIDE_PARAM) - 8'd1);
    assign pix_clear = (state_q != StWrite) || !sys_vaild;

    frame_pattern_pixel #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_pixel (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pix_clear),
        .advance    (write_hit),
        .pattern    (pattern_q),
        .pix_data   (sys_data),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pattern_q  <= PatBars;
            dly_q      <= '0;
            thr_q      <= '0;
            sys_load   <= 1'b0;
            sys_we     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sys_we <= 1'b0;
            if (state_q != StIdle && !sys_vaild) begin
                state_q    <= StIdle;
                dly_q      <= '0;
                thr_q      <= '0;
                sys_load   <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (sys_vaild) begin
                            state_q <= StWait;
                            dly_q   <= '0;
                        end
                    end
                    StWait: begin
                        if (dly_q == DlyW'(START_DELAY - 1)) begin
                            state_q   <= StLoad;
                            dly_q     <= '0;
                            sys_load  <= 1'b1;
                            pattern_q <= pattern_e'(pattern_sel);
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    StLoad: begin
                        if (dly_q == DlyW'(LOAD_LEN - 1)) begin
                            state_q  <= StWrite;
                            dly_q    <= '0;
                            thr_q    <= '0;
                            sys_load <= 1'b0;
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    StWrite: begin
                        if (write_hit) begin
                            thr_q  <= '0;
                            sys_we <= 1'b1;
                            if (last_pixel) begin
                                state_q    <= StDone;
                                frame_done <= 1'b1;
                            end
                        end else begin
                            thr_q <= thr_q + 8'd1;
                        end
                    end
                    StDone: begin
                        if (restart) begin
                            state_q    <= StLoad;
                            dly_q      <= '0;
                            sys_load   <= 1'b1;
                            frame_done <= 1'b0;
                            pattern_q  <= pattern_e'(pattern_sel);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
